// File: rtl/instr_fetch_unit.sv
// Fetches 16-bit instructions as two byte reads (low byte, then high byte)
// from a 256x8 memory and offers them to decode over a valid/ready handshake.
module instr_fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        pc_load,
  input  logic [7:0]  pc_load_val,
  output logic [7:0]  mem_addr,
  output logic        mem_cs,
  output logic        mem_wr,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  pc,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  pc_nxt;
  logic [15:0] instr_nxt;
  logic        valid_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 16'h0000;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      instr_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    valid_nxt = instr_valid;
    case (state)
      IDLE: begin
        if (enable) state_nxt = FETCH_LO;
      end
      FETCH_LO: begin
        instr_nxt[7:0] = mem_rdata;
        pc_nxt         = pc + 8'd1;
        state_nxt      = FETCH_HI;
      end
      FETCH_HI: begin
        instr_nxt[15:8] = mem_rdata;
        pc_nxt          = pc + 8'd1;
        valid_nxt       = 1'b1;
        state_nxt       = HOLD;
      end
      HOLD: begin
        if (instr_valid && instr_ready) begin
          valid_nxt = 1'b0;
          state_nxt = enable ? FETCH_LO : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Redirect wins over everything; a half-assembled instruction is dropped.
    if (pc_load) begin
      pc_nxt    = pc_load_val;
      instr_nxt = instr;
      valid_nxt = 1'b0;
      state_nxt = enable ? FETCH_LO : IDLE;
    end
  end

  assign busy     = (state == FETCH_LO) || (state == FETCH_HI);
  assign mem_cs   = ~busy;
  assign mem_wr   = 1'b0;
  assign mem_addr = pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: stimulus pushes expected instructions
// into a queue, a negedge monitor pops them on each handshake.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        pc_load;
  logic [7:0]  pc_load_val;
  logic [7:0]  mem_addr;
  logic        mem_cs;
  logic        mem_wr;
  logic [7:0]  mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  pc;
  logic        busy;

  logic [7:0] ram [256];

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  pc;
  } exp_t;
  exp_t expq[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr];

  instr_fetch_unit #(.RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .mem_addr    (mem_addr),
    .mem_cs      (mem_cs),
    .mem_wr      (mem_wr),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] i, input logic [7:0] p);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    expq.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    if (!instr_valid) chk("wait_valid_timeout", 16'd0, 16'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      tick();
      n++;
    end while ((busy || instr_valid) && n < 20);
    if (busy || instr_valid) chk("wait_idle_timeout", 16'd0, 16'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("bus_invariant", {13'd0, mem_wr, mem_cs, (mem_addr == pc)}, {13'd0, 1'b0, ~busy, 1'b1});
      if (instr_valid && instr_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_instr", instr, 16'hxxxx);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("instr", instr, e.instr);
          chk("instr_pc", {8'd0, pc}, {8'd0, e.pc});
        end
      end
    end
  end

  initial begin
    int lows;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h00] = 8'h34; ram[8'h01] = 8'h12;
    ram[8'h02] = 8'h78; ram[8'h03] = 8'h56;
    ram[8'h04] = 8'h9A; ram[8'h05] = 8'hBC;
    ram[8'h10] = 8'h11; ram[8'h11] = 8'h22;
    ram[8'h40] = 8'h44; ram[8'h41] = 8'h55;
    ram[8'hFF] = 8'hAA;

    rst_n = 1'b0; enable = 1'b0; pc_load = 1'b0; pc_load_val = 8'h00; instr_ready = 1'b0;
    #3;
    chk("rst_pc", {8'd0, pc}, 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_cs", {15'd0, mem_cs}, 16'd1);
    chk("rst_wr", {15'd0, mem_wr}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);

    // Single fetch from 00, enable dropped during FETCH_LO
    tick();
    rst_n = 1'b1; enable = 1'b1; instr_ready = 1'b1;
    push(16'h1234, 8'h02);
    tick();
    enable = 1'b0;
    lows = 0;
    repeat (5) begin
      @(negedge clk);
      if (!mem_cs) lows++;
    end
    chk("cs_low_cycles", lows[15:0], 16'd2);
    chk("t1_idle_pc", {8'd0, pc}, 16'h0002);
    chk("t1_idle_cs", {15'd0, mem_cs}, 16'd1);
    chk("t1_idle_busy", {15'd0, busy}, 16'd0);

    // Backpressure: hold for 5 cycles, then release with enable kept high
    tick();
    instr_ready = 1'b0; enable = 1'b1;
    push(16'h5678, 8'h04);
    push(16'hBC9A, 8'h06);
    wait_valid();
    repeat (5) begin
      tick();
      chk("hold_instr", instr, 16'h5678);
      chk("hold_state", {7'd0, pc, mem_cs}, {7'd0, 8'h04, 1'b1});
    end
    instr_ready = 1'b1;
    tick();
    chk("restart_busy", {15'd0, busy}, 16'd1);
    enable = 1'b0;
    wait_idle();
    chk("t2_pc", {8'd0, pc}, 16'h0006);

    // Wrap-around fetch from FF
    ram[8'h00] = 8'hBB;
    push(16'hBBAA, 8'h01);
    tick();
    pc_load = 1'b1; pc_load_val = 8'hFF; enable = 1'b1;
    tick();
    pc_load = 1'b0; enable = 1'b0;
    wait_idle();
    chk("wrap_pc", {8'd0, pc}, 16'h0001);

    // Redirect to 40 while fetching the high byte at 11
    push(16'h5544, 8'h42);
    tick();
    pc_load = 1'b1; pc_load_val = 8'h10; enable = 1'b1;
    tick();
    pc_load = 1'b0;
    tick();
    chk("redir_hi_pc", {7'd0, pc, busy}, {7'd0, 8'h11, 1'b1});
    pc_load = 1'b1; pc_load_val = 8'h40;
    tick();
    chk("redir_state", {6'd0, pc, instr_valid, busy}, {6'd0, 8'h40, 1'b0, 1'b1});
    pc_load = 1'b0; enable = 1'b0;
    wait_idle();
    chk("redir_pc", {8'd0, pc}, 16'h0042);

    // Asynchronous reset between edges during FETCH_LO
    tick();
    enable = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cs", {15'd0, mem_cs}, 16'd1);
    chk("arst_valid_busy", {14'd0, instr_valid, busy}, 16'd0);
    chk("arst_pc", {8'd0, pc}, 16'h0000);
    chk("arst_addr", {8'd0, mem_addr}, 16'h0000);
    tick();
    ram[8'h01] = 8'h12;
    push(16'h12BB, 8'h02);
    rst_n = 1'b1;
    tick();
    enable = 1'b0;
    wait_idle();
    chk("arst_restart_pc", {8'd0, pc}, 16'h0002);

    // Handshake and redirect on the same edge: transfer counts, then redirect
    tick();
    instr_ready = 1'b0; enable = 1'b1;
    push(16'h5678, 8'h04);
    tick();
    enable = 1'b0;
    wait_valid();
    instr_ready = 1'b1; pc_load = 1'b1; pc_load_val = 8'h80;
    tick();
    pc_load = 1'b0;
    chk("hs_load_state", {6'd0, pc, instr_valid, busy}, {6'd0, 8'h80, 1'b0, 1'b0});

    for (int n = 0; n < 20 && expq.size() != 0; n++) tick();
    chk("queue_drain", expq.size(), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Bus initiator that drives the 256x8 memory's read port (address, active-low chip select, write strobe) and sequences two byte reads per instruction.
- Assembles each 16-bit instruction, low byte first then high byte, matching the IR's lh=0 / lh=1 load order.
- Presents the instruction to the decode stage over a valid/ready handshake.
- Owns the fetch program counter; the control unit may redirect it (branch/jump).

Parameters:
- RESET_PC, 8'h00, fetch address loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  permit new instruction fetches.
- pc_load  input  1  redirect fetch PC this cycle.
- pc_load_val  input  8  new PC value when pc_load=1.
- mem_addr  output  8  memory address.
- mem_cs  output  1  memory chip select, active-low (0 = selected).
- mem_wr  output  1  memory write strobe; tied 0 (read only).
- mem_rdata  input  8  memory read data; combinational in the same cycle as address/cs.
- instr  output  16  assembled instruction {hi byte, lo byte}.
- instr_valid  output  1  instr holds a complete, unconsumed instruction.
- instr_ready  input  1  decode stage accepts instr.
- pc  output  8  current fetch PC (address of the next byte to read).
- busy  output  1  high in FETCH_LO or FETCH_HI.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, pc=RESET_PC, instr=16'h0000, instr_valid=0.
  - mem_cs=1, mem_wr=0, busy=0.
  - Outputs take these values immediately on assertion, not at the next edge.
- FSM states: IDLE, FETCH_LO, FETCH_HI, HOLD.
  - mem_cs=0 only in FETCH_LO/FETCH_HI; 1 otherwise.
  - mem_addr=pc in all states.
- IDLE: enable=1 -> FETCH_LO; else stay.
- FETCH_LO: at edge, instr[7:0]<=mem_rdata, pc<=pc+1, -> FETCH_HI.
- FETCH_HI: at edge, instr[15:8]<=mem_rdata, pc<=pc+1, instr_valid<=1, -> HOLD.
- HOLD:
  - mem_cs=1; instr and pc stable while instr_valid=1 and instr_ready=0.
  - When instr_valid and instr_ready are both high at an edge: instr_valid<=0, then -> FETCH_LO if enable=1, else -> IDLE.
- Latency: enable sampled in IDLE at edge N gives instr_valid=1 after edge N+2.
- Throughput with instr_ready held 1: one instruction per 3 cycles.
- PC arithmetic is 8-bit modulo: 8'hFF+1=8'h00. An instruction whose low byte is at 8'hFF takes its high byte from 8'h00.
- enable deasserted mid-fetch: the current instruction completes (LO->HI->HOLD); no further fetch is started after the handshake.
- pc_load=1 (any state, highest priority):
  - pc<=pc_load_val, instr_valid<=0.
  - Any partial instruction is discarded; state -> FETCH_LO if enable=1, else IDLE.
  - If instr_valid and instr_ready are also high that edge, the decode stage has taken the instruction (transfer counts). The unit still discards and redirects.
- instr[15:8] may hold the stale high byte while the next low byte is being fetched. Consumers qualify instr with instr_valid only.
- mem_wr is never 1. mem_cs is never 0 in IDLE, in HOLD, or during reset.

Test Plan:
- RAM[00]=34, RAM[01]=12, enable=1, instr_ready=1 -> instr=16'h1234 with instr_valid=1 after the 3rd edge; pc=02; mem_cs low for exactly 2 cycles.
- Same setup, instr_ready=0 for 5 cycles after valid -> instr=1234, pc=02, mem_cs=1 held stable. Raising ready gives one handshake, then fetch from 02 restarts.
- pc_load=1 with pc_load_val=FF, RAM[FF]=AA, RAM[00]=BB -> instr=16'hBBAA, pc=01 (wrap-around).
- pc_load=1 with pc_load_val=40 while in FETCH_HI of the fetch at 10 -> no valid for the 10 instruction; next instr comes from RAM[41:40]; pc=42.
- rst_n pulsed low mid-FETCH_LO (between edges) -> immediately mem_cs=1, instr_valid=0, pc=RESET_PC. After release with enable=1, fetch restarts at RESET_PC.
- enable dropped during FETCH_LO -> that instruction still completes and handshakes, then the FSM sits in IDLE with mem_cs=1 and pc unchanged.
